// File: rtl/stream_xbar.sv
// Stream crossbar: one host stream pair routed to one of N_MODULES accelerator ports via cfg_sel.
// Optional `STREAM_XBAR_LOCK_EN rejects config writes while either direction buffer holds data.

module stream_xbar_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_empty,
  output logic         o_full
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] r_mem;
  logic [AW-1:0]           r_wptr, r_rptr;
  logic [AW:0]             r_cnt;
  logic                    w_push, w_pop;

  // Guarded so occupancy can never leave [0, DEPTH] even if a caller misbehaves.
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_data  = r_mem[r_rptr];
  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == (AW+1)'(DEPTH));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mem  <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: ;
      endcase
    end
  end
endmodule

module stream_xbar #(
  parameter int N_MODULES  = 2,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [$clog2(N_MODULES)-1:0] xbar_config,
  input  logic                         xbar_val,
  input  logic                         i_stream_val,
  output logic                         i_stream_rdy,
  input  logic [31:0]                  i_stream_data,
  output logic                         o_stream_val,
  input  logic                         o_stream_rdy,
  output logic [31:0]                  o_stream_data,
  output logic [N_MODULES-1:0]         mod_in_val,
  input  logic [N_MODULES-1:0]         mod_in_rdy,
  output logic [32*N_MODULES-1:0]      mod_in_data,
  input  logic [N_MODULES-1:0]         mod_out_val,
  output logic [N_MODULES-1:0]         mod_out_rdy,
  input  logic [32*N_MODULES-1:0]      mod_out_data,
  output logic [$clog2(N_MODULES)-1:0] cfg_sel,
  output logic                         cfg_err
);
  localparam int SW = $clog2(N_MODULES);
  localparam logic [SW:0] NMOD = (SW+1)'(N_MODULES);

  logic [SW-1:0] r_sel;
  logic          r_err, r_live;
  logic          w_fwd_empty, w_fwd_full, w_rev_empty, w_rev_full;
  logic [31:0]   w_fwd_head, w_rev_head, w_sel_out_data;
  logic          w_sel_in_rdy, w_sel_out_val;
  logic          w_cfg_ok, w_lock;

  assign w_cfg_ok = ({1'b0, xbar_config} < NMOD);
`ifdef STREAM_XBAR_LOCK_EN
  assign w_lock = ~w_fwd_empty | ~w_rev_empty;
`else
  assign w_lock = 1'b0;
`endif

  // r_live holds both ready paths low until the first edge after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sel  <= '0;
      r_err  <= 1'b0;
      r_live <= 1'b0;
    end else begin
      r_live <= 1'b1;
      r_err  <= 1'b0;
      if (xbar_val) begin
        if (w_cfg_ok && !w_lock) r_sel <= xbar_config;
        else                     r_err <= 1'b1;
      end
    end
  end

  assign cfg_sel       = r_sel;
  assign cfg_err       = r_err;
  assign i_stream_rdy  = r_live & ~w_fwd_full;
  assign o_stream_val  = ~w_rev_empty;
  assign o_stream_data = w_rev_head;

  always_comb begin
    mod_in_val     = '0;
    mod_in_data    = '0;
    mod_out_rdy    = '0;
    w_sel_in_rdy   = 1'b0;
    w_sel_out_val  = 1'b0;
    w_sel_out_data = '0;
    for (int k = 0; k < N_MODULES; k++) begin
      if (r_sel == SW'(k)) begin
        mod_in_val[k]          = ~w_fwd_empty;
        mod_in_data[32*k +: 32] = w_fwd_head;
        mod_out_rdy[k]         = r_live & ~w_rev_full;
        w_sel_in_rdy           = mod_in_rdy[k];
        w_sel_out_val          = mod_out_val[k];
        w_sel_out_data         = mod_out_data[32*k +: 32];
      end
    end
  end

  stream_xbar_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_fwd (
    .clk     (clk),
    .reset   (reset),
    .i_push  (i_stream_val & i_stream_rdy),
    .i_data  (i_stream_data),
    .i_pop   (~w_fwd_empty & w_sel_in_rdy),
    .o_data  (w_fwd_head),
    .o_empty (w_fwd_empty),
    .o_full  (w_fwd_full)
  );

  stream_xbar_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_rev (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_sel_out_val & r_live & ~w_rev_full),
    .i_data  (w_sel_out_data),
    .i_pop   (~w_rev_empty & o_stream_rdy),
    .o_data  (w_rev_head),
    .o_empty (w_rev_empty),
    .o_full  (w_rev_full)
  );
endmodule

// File: tb/tb_stream_xbar.sv
// Bench for stream_xbar (3 modules, depth 2): directed scenarios then random traffic,
// all checked against a queue-based model of the crossbar.
module tb_stream_xbar;
  localparam int N  = 3;
  localparam int D  = 2;
  localparam int SW = $clog2(N);
`ifdef STREAM_XBAR_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [SW-1:0]   xbar_config = '0;
  logic            xbar_val = 1'b0;
  logic            i_stream_val = 1'b0, i_stream_rdy;
  logic [31:0]     i_stream_data = '0;
  logic            o_stream_val, o_stream_rdy = 1'b0;
  logic [31:0]     o_stream_data;
  logic [N-1:0]    mod_in_val, mod_in_rdy = '0;
  logic [32*N-1:0] mod_in_data;
  logic [N-1:0]    mod_out_val = '0, mod_out_rdy;
  logic [32*N-1:0] mod_out_data = '0;
  logic [SW-1:0]   cfg_sel;
  logic            cfg_err;

  stream_xbar #(.N_MODULES(N), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .xbar_config(xbar_config), .xbar_val(xbar_val),
    .i_stream_val(i_stream_val), .i_stream_rdy(i_stream_rdy), .i_stream_data(i_stream_data),
    .o_stream_val(o_stream_val), .o_stream_rdy(o_stream_rdy), .o_stream_data(o_stream_data),
    .mod_in_val(mod_in_val), .mod_in_rdy(mod_in_rdy), .mod_in_data(mod_in_data),
    .mod_out_val(mod_out_val), .mod_out_rdy(mod_out_rdy), .mod_out_data(mod_out_data),
    .cfg_sel(cfg_sel), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: beats in flight per direction, plus config state.
  logic [31:0] fwd_q[$];
  logic [31:0] rev_q[$];
  int          m_sel  = 0;
  bit          m_err  = 1'b0;
  bit          m_live = 1'b0;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    fwd_q.delete();
    rev_q.delete();
    m_sel  = 0;
    m_err  = 1'b0;
    m_live = 1'b0;
  endtask

  task automatic check_all();
    logic [N-1:0]    selm;
    logic [32*N-1:0] other;
    selm  = N'(1) << m_sel;
    other = '1;
    other[32*m_sel +: 32] = '0;
    chk("i_stream_rdy", 96'(i_stream_rdy), 96'(m_live && fwd_q.size() < D));
    chk("mod_in_val", 96'(mod_in_val), 96'((fwd_q.size() > 0) ? selm : '0));
    chk("mod_in_data_other", 96'(mod_in_data & other), 96'(0));
    if (fwd_q.size() > 0) chk("mod_in_data", 96'(mod_in_data[32*m_sel +: 32]), 96'(fwd_q[0]));
    chk("mod_out_rdy", 96'(mod_out_rdy), 96'((m_live && rev_q.size() < D) ? selm : '0));
    chk("o_stream_val", 96'(o_stream_val), 96'(rev_q.size() > 0));
    if (rev_q.size() > 0) chk("o_stream_data", 96'(o_stream_data), 96'(rev_q[0]));
    chk("cfg_sel", 96'(cfg_sel), 96'(m_sel));
    chk("cfg_err", 96'(cfg_err), 96'(m_err));
  endtask

  // Check current outputs, predict the transfers of this cycle, then cross the edge.
  task automatic step();
    bit fpush, fpop, rpush, rpop, busy, cfg_ok;
    logic [31:0] fdat, rdat;
    check_all();
    fpush  = i_stream_val && m_live && fwd_q.size() < D;
    fpop   = fwd_q.size() > 0 && mod_in_rdy[m_sel];
    rpush  = mod_out_val[m_sel] && m_live && rev_q.size() < D;
    rpop   = rev_q.size() > 0 && o_stream_rdy;
    busy   = fwd_q.size() > 0 || rev_q.size() > 0;
    cfg_ok = int'(xbar_config) < N && !(LOCK && busy);
    fdat   = i_stream_data;
    rdat   = mod_out_data[32*m_sel +: 32];
    @(posedge clk);
    if (!reset) model_reset();
    else begin
      m_err = 1'b0;
      if (xbar_val) begin
        if (cfg_ok) m_sel = int'(xbar_config);
        else        m_err = 1'b1;
      end
      if (fpop)  void'(fwd_q.pop_front());
      if (fpush) fwd_q.push_back(fdat);
      if (rpop)  void'(rev_q.pop_front());
      if (rpush) rev_q.push_back(rdat);
      m_live = 1'b1;
    end
    #2;
  endtask

  task automatic write_cfg(input int idx);
    xbar_config = SW'(idx);
    xbar_val    = 1'b1;
    step();
    xbar_val    = 1'b0;
  endtask

  // Offer one forward beat until the model says it was taken; bounded.
  task automatic send_fwd(input logic [31:0] d);
    bit took;
    took = 1'b0;
    i_stream_val  = 1'b1;
    i_stream_data = d;
    for (int i = 0; i < 20 && !took; i++) begin
      took = m_live && fwd_q.size() < D;
      step();
    end
    i_stream_val = 1'b0;
    checks++;
    assert (took) else begin
      errors++;
      $error("FAIL send_fwd_timeout observed=0 expected=1 beat=%0h", d);
    end
  endtask

  initial begin
    // Reset state
    #3;
    check_all();
    chk("rst_i_rdy", 96'(i_stream_rdy), 96'(0));
    step();
    step();
    reset = 1'b1;
    step();
    chk("live_after_first_edge_i", 96'(i_stream_rdy), 96'(1));
    chk("live_after_first_edge_o", 96'(mod_out_rdy), 96'(3'b001));

    // Basic route to module 1, one-cycle latency
    mod_in_rdy = '0;
    write_cfg(1);
    chk("route_sel", 96'(cfg_sel), 96'(1));
    i_stream_val  = 1'b1;
    i_stream_data = 32'hDEADBEEF;
    step();
    i_stream_val  = 1'b0;
    chk("route_val", 96'(mod_in_val), 96'(3'b010));
    chk("route_data", 96'(mod_in_data[63:32]), 96'(32'hDEADBEEF));
    mod_in_rdy = 3'b010;
    step();
    step();

    // Backpressure: third beat stalls, order kept on release
    mod_in_rdy = '0;
    send_fwd(32'h1);
    send_fwd(32'h2);
    i_stream_val  = 1'b1;
    i_stream_data = 32'h3;
    step();
    chk("bp_full", 96'(i_stream_rdy), 96'(0));
    chk("bp_head", 96'(mod_in_data[63:32]), 96'(32'h1));
    step();
    mod_in_rdy = 3'b010;
    send_fwd(32'h3);
    for (int i = 0; i < 4; i++) step();

    // Return path held under o_stream_rdy=0
    write_cfg(0);
    o_stream_rdy = 1'b0;
    mod_out_val  = 3'b001;
    mod_out_data[31:0] = 32'h12345678;
    for (int i = 0; i < 5; i++) step();
    chk("ret_val", 96'(o_stream_val), 96'(1));
    chk("ret_data", 96'(o_stream_data), 96'(32'h12345678));
    chk("ret_full", 96'(mod_out_rdy), 96'(0));
    mod_out_val  = '0;
    o_stream_rdy = 1'b1;
    for (int i = 0; i < 3; i++) step();

    // Illegal config index
    write_cfg(1);
    write_cfg(3);
    chk("bad_sel", 96'(cfg_sel), 96'(1));
    chk("bad_err", 96'(cfg_err), 96'(1));
    step();
    chk("bad_err_clear", 96'(cfg_err), 96'(0));

    // Config change with a queued beat
    write_cfg(0);
    mod_in_rdy = '0;
    send_fwd(32'hCAFE0001);
    write_cfg(1);
    chk("lock_sel", 96'(cfg_sel), 96'(LOCK ? 0 : 1));
    chk("lock_err", 96'(cfg_err), 96'(LOCK));
    mod_in_rdy = 3'b011;
    for (int i = 0; i < 3; i++) step();

    // Async reset mid-cycle with two beats queued
    write_cfg(2);
    mod_in_rdy = '0;
    send_fwd(32'hA1);
    send_fwd(32'hA2);
    check_all();
    #2;
    reset = 1'b0;
    #1;
    chk("arst_i_rdy", 96'(i_stream_rdy), 96'(0));
    chk("arst_in_val", 96'(mod_in_val), 96'(0));
    chk("arst_out_rdy", 96'(mod_out_rdy), 96'(0));
    chk("arst_o_val", 96'(o_stream_val), 96'(0));
    chk("arst_sel", 96'(cfg_sel), 96'(0));
    chk("arst_err", 96'(cfg_err), 96'(0));
    model_reset();
    @(posedge clk);
    #2;
    reset = 1'b1;
    mod_in_rdy = '1;
    for (int i = 0; i < 4; i++) step();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      xbar_val      = ($urandom_range(0, 7) == 0);
      xbar_config   = SW'($urandom_range(0, 3));
      i_stream_val  = 1'($urandom);
      i_stream_data = $urandom;
      mod_in_rdy    = N'($urandom);
      mod_out_val   = N'($urandom);
      mod_out_data  = {$urandom, $urandom, $urandom};
      o_stream_rdy  = 1'($urandom);
      step();
    end
    xbar_val = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
